time_set_ctrl: RTL and testbench
================================

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 Parameter CLK_HZ, default 100000000: clock frequency, documentation only; all timing uses the cycle parameters below.
REQ-002 Parameter HOLD_CYC, default 50000000: cycles btn_up must be held before auto-repeat starts.
REQ-003 Parameter REPEAT_CYC, default 20000000: cycles between auto-repeat pulses.
REQ-004 Parameter BLINK_CYC, default 25000000: blink half-period in cycles.
REQ-005 Parameter TIMEOUT_CYC, default 1000000000: idle cycles in a set mode before automatic return to RUN.
REQ-006 Port clk, input, 1: system clock; all logic is on its rising edge.
REQ-007 Port reset, input, 1: asynchronous, active-high reset.
REQ-008 Port run_en, input, 1: run-enable switch level.
REQ-009 Port btn_mode, input, 1: debounced level of the mode button.
REQ-010 Port btn_up, input, 1: debounced level of the increment button.
REQ-011 Port clk_en, output, 1: count enable to the timekeeping counter.
REQ-012 Port hrup, output, 1: single-cycle hour-increment pulse.
REQ-013 Port minup, output, 1: single-cycle minute-increment pulse.
REQ-014 Port blank_hr, output, 1: blank the hour digits.
REQ-015 Port blank_min, output, 1: blank the minute digits.
REQ-016 Port mode, output, 2: current state; 0=RUN, 1=SET_HR, 2=SET_MIN.

Function
REQ-017 The block SHALL register btn_mode and btn_up once and detect rising edges as prev=0 and cur=1; the edge SHALL act in the cycle after the level rises.
REQ-018 The FSM SHALL step RUN->SET_HR->SET_MIN->RUN, one step per btn_mode rising edge; encoding 3 SHALL recover to RUN.
REQ-019 clk_en SHALL equal run_en AND (mode==RUN), registered.
REQ-020 In SET_HR, a btn_up rising edge SHALL produce exactly one hrup pulse one cycle after the edge; SET_MIN behaves the same with minup.
REQ-021 btn_up edges and holds SHALL be ignored in RUN; no pulses.
REQ-022 Holding btn_up for HOLD_CYC cycles after the edge SHALL produce a further pulse, then one pulse every REPEAT_CYC cycles while held; release SHALL stop repeat at once.
REQ-023 hrup and minup SHALL never be high in the same cycle, and each SHALL be high for no more than one consecutive cycle.
REQ-024 A btn_mode edge coinciding with a btn_up edge or a repeat pulse SHALL take priority: the mode advances, no pulse is issued, and the hold counter clears.
REQ-025 The blink phase SHALL toggle every BLINK_CYC cycles and restart in the visible phase on every mode change and every increment pulse.
REQ-026 In SET_HR, blank_hr SHALL be 1 during the off phase; likewise blank_min in SET_MIN; both blank outputs SHALL be 0 in RUN.
REQ-027 The idle counter SHALL clear on any button edge or pulse; at TIMEOUT_CYC it SHALL force RUN.
REQ-028 Counters SHALL saturate or reload and SHALL NOT wrap into spurious events; widths SHALL be $clog2(parameter+1).

Reset
REQ-029 Reset SHALL give mode=RUN, hrup=minup=0, blank_hr=blank_min=0, clk_en=0, and all counters and edge registers zero.
REQ-030 Reset asserted mid-set or mid-repeat SHALL abort immediately; after release, a button already held SHALL NOT create an edge until it is released and pressed again.

Structure
REQ-031 Mode encodings (RUN, SET_HR, SET_MIN) SHALL live in a shared clock_pkg with the default cycle constants.
REQ-032 A sub-module btn_repeat (edge detect plus hold/repeat counter) SHALL be instantiated once for btn_up.

Verification (HOLD_CYC=8, REPEAT_CYC=4, BLINK_CYC=5, TIMEOUT_CYC=50)
REQ-033 Two btn_mode presses, then a 1-cycle btn_up press -> mode=2, exactly one minup pulse, hrup stays 0.
REQ-034 In SET_HR, hold btn_up for 20 cycles -> hrup pulses at offsets 1, 9, 13 and 17 only.
REQ-035 Enter SET_HR, then idle -> blank_hr toggles every 5 cycles; mode returns to 0 after 50 idle cycles; clk_en=run_en.
REQ-036 btn_mode and btn_up rise in the same cycle while in SET_HR -> mode=2 and no hrup or minup pulse.
REQ-037 Assert reset while repeating in SET_MIN with btn_up held -> all outputs reset at once; after release, no minup until btn_up is released and re-pressed.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared mode encodings and default cycle constants for the clock-setting logic.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2
  } mode_e;

  localparam int unsigned CLK_HZ_DEF      = 100_000_000;
  localparam int unsigned HOLD_CYC_DEF    = 50_000_000;
  localparam int unsigned REPEAT_CYC_DEF  = 20_000_000;
  localparam int unsigned BLINK_CYC_DEF   = 25_000_000;
  localparam int unsigned TIMEOUT_CYC_DEF = 1_000_000_000;

  function automatic int unsigned maxOf(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_repeat.sv
// Button rising-edge detect with hold-then-repeat; pulse is combinational in the edge cycle.
// No backpressure: clear suppresses pulses and drops any hold in progress.
module btn_repeat
  import clock_pkg::*;
#(
  parameter int unsigned HOLD_CYC   = HOLD_CYC_DEF,
  parameter int unsigned REPEAT_CYC = REPEAT_CYC_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  input  logic clear,
  output logic rise,
  output logic pulse
);

  localparam int unsigned CNT_W = $clog2(maxOf(HOLD_CYC, REPEAT_CYC) + 1);
  localparam logic [CNT_W-1:0] HOLD_V = CNT_W'(HOLD_CYC);
  localparam logic [CNT_W-1:0] REP_V  = CNT_W'(REPEAT_CYC);

  logic             btnQ;
  logic             armed;
  logic             holding;
  logic             repeating;
  logic             repeatHit;
  logic [CNT_W-1:0] holdCnt;

  // armed stays low until the button is seen released, so a press held
  // through reset never looks like a fresh edge.
  assign rise      = btn & ~btnQ & armed;
  assign repeatHit = holding & btn & (holdCnt == (repeating ? REP_V : HOLD_V));
  assign pulse     = ~clear & (rise | repeatHit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btnQ      <= 1'b0;
      armed     <= 1'b0;
      holding   <= 1'b0;
      repeating <= 1'b0;
      holdCnt   <= '0;
    end else begin
      btnQ  <= btn;
      armed <= armed | ~btn;
      if (clear || !btn) begin
        holding   <= 1'b0;
        repeating <= 1'b0;
        holdCnt   <= '0;
      end else if (rise || repeatHit) begin
        holding   <= 1'b1;
        repeating <= repeatHit;
        holdCnt   <= CNT_W'(1);
      end else if (holding && holdCnt != '1) begin
        holdCnt <= holdCnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Clock set-mode controller: mode FSM, hour/minute increment pulses, digit blink, idle timeout.
// Outputs are registered one cycle after the qualifying button edge; no backpressure.
module time_set_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned CLK_HZ      = CLK_HZ_DEF,
  parameter int unsigned HOLD_CYC    = HOLD_CYC_DEF,
  parameter int unsigned REPEAT_CYC  = REPEAT_CYC_DEF,
  parameter int unsigned BLINK_CYC   = BLINK_CYC_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run_en,
  input  logic       btn_mode,
  input  logic       btn_up,
  output logic       clk_en,
  output logic       hrup,
  output logic       minup,
  output logic       blank_hr,
  output logic       blank_min,
  output logic [1:0] mode
);

  localparam int unsigned IDLE_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned BLINK_W = $clog2(BLINK_CYC + 1);
  localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(TIMEOUT_CYC - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYC - 1);

  if (CLK_HZ == 0 || BLINK_CYC == 0 || TIMEOUT_CYC == 0) begin : gBadParam
    $error("time_set_ctrl: CLK_HZ, BLINK_CYC and TIMEOUT_CYC must be non-zero");
  end

  mode_e               state;
  mode_e               stateNext;
  logic                modeQ;
  logic                modeArmed;
  logic                modeRise;
  logic                setMode;
  logic                upClear;
  logic                upRise;
  logic                upPulse;
  logic                incEvent;
  logic                activity;
  logic                timeout;
  logic                blinkRestart;
  logic                blinkOff;
  logic [IDLE_W-1:0]   idleCnt;
  logic [BLINK_W-1:0]  blinkCnt;

  assign modeRise = btn_mode & ~modeQ & modeArmed;
  assign setMode  = (state == SET_HR) || (state == SET_MIN);

  // A mode press wins over any increment in the same cycle and drops the hold.
  assign upClear = modeRise | ~setMode;

  btn_repeat #(
    .HOLD_CYC   (HOLD_CYC),
    .REPEAT_CYC (REPEAT_CYC)
  ) u_upRepeat (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_up),
    .clear (upClear),
    .rise  (upRise),
    .pulse (upPulse)
  );

  assign incEvent     = upPulse & ~(hrup | minup);
  assign activity     = modeRise | upRise | upPulse;
  assign timeout      = setMode & ~activity & (idleCnt == IDLE_LAST);
  assign blinkRestart = (stateNext != state) | incEvent;

  always_comb begin
    stateNext = state;
    case (state)
      RUN:     if (modeRise) stateNext = SET_HR;
      SET_HR:  if (modeRise) stateNext = SET_MIN;
               else if (timeout) stateNext = RUN;
      SET_MIN: if (modeRise || timeout) stateNext = RUN;
      default: stateNext = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      modeQ     <= 1'b0;
      modeArmed <= 1'b0;
      hrup      <= 1'b0;
      minup     <= 1'b0;
      clk_en    <= 1'b0;
      idleCnt   <= '0;
      blinkCnt  <= '0;
      blinkOff  <= 1'b0;
    end else begin
      state     <= stateNext;
      modeQ     <= btn_mode;
      modeArmed <= modeArmed | ~btn_mode;
      hrup      <= incEvent & (state == SET_HR);
      minup     <= incEvent & (state == SET_MIN);
      clk_en    <= run_en & (state == RUN);

      if (activity || !setMode) begin
        idleCnt <= '0;
      end else if (idleCnt != '1) begin
        idleCnt <= idleCnt + IDLE_W'(1);
      end

      if (blinkRestart) begin
        blinkCnt <= '0;
        blinkOff <= 1'b0;
      end else if (blinkCnt == BLINK_LAST) begin
        blinkCnt <= '0;
        blinkOff <= ~blinkOff;
      end else begin
        blinkCnt <= blinkCnt + BLINK_W'(1);
      end
    end
  end

  assign mode      = state;
  assign blank_hr  = (state == SET_HR) & blinkOff;
  assign blank_min = (state == SET_MIN) & blinkOff;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed and randomized bench for time_set_ctrl against a time-arithmetic reference model.
module tb_time_set_ctrl;

  localparam int HOLD    = 8;
  localparam int REPEAT  = 4;
  localparam int BLINK   = 5;
  localparam int TIMEOUT = 50;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run_en = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_up = 1'b0;
  logic       clk_en;
  logic       hrup;
  logic       minup;
  logic       blank_hr;
  logic       blank_min;
  logic [1:0] mode;

  time_set_ctrl #(
    .HOLD_CYC    (HOLD),
    .REPEAT_CYC  (REPEAT),
    .BLINK_CYC   (BLINK),
    .TIMEOUT_CYC (TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .run_en    (run_en),
    .btn_mode  (btn_mode),
    .btn_up    (btn_up),
    .clk_en    (clk_en),
    .hrup      (hrup),
    .minup     (minup),
    .blank_hr  (blank_hr),
    .blank_min (blank_min),
    .mode      (mode)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: mode as 0/1/2, press and restart moments as cycle numbers.
  int t = 0;
  int mMode = 0;
  int pressT = -1;
  int lastAct = 0;
  int lastRestart = 0;
  bit prevM = 0, prevU = 0, lowM = 0, lowU = 0;
  bit eHr = 0, eMin = 0, eBh = 0, eBm = 0, eClk = 0;
  int eMode = 0;
  logic lastHr = 0, lastMin = 0;
  int hrCnt = 0, minCnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  task automatic modelReset();
    mMode = 0; eMode = 0; pressT = -1;
    lastAct = t; lastRestart = t;
    prevM = 0; prevU = 0; lowM = 0; lowU = 0;
    eHr = 0; eMin = 0; eBh = 0; eBm = 0; eClk = 0;
    lastHr = 0; lastMin = 0;
  endtask

  task automatic modelStep(input logic m, input logic u, input logic r);
    bit mRise, uRise, setM, clr, rep, evt, act;
    int k, nMode, off;
    t++;
    mRise = m && !prevM && lowM;
    uRise = u && !prevU && lowU;
    setM  = (mMode != 0);
    clr   = mRise || !setM;
    rep   = 0;
    if (pressT >= 0 && u) begin
      k   = t - pressT;
      rep = (k == HOLD) || (k > HOLD && ((k - HOLD) % REPEAT) == 0);
    end
    evt = !clr && (uRise || rep);
    act = mRise || uRise || evt;
    nMode = mMode;
    if (mRise) nMode = (mMode + 1) % 3;
    else if (setM && !act && (t - lastAct) >= TIMEOUT) nMode = 0;
    if (act) lastAct = t;
    if (clr || !u) pressT = -1;
    else if (uRise) pressT = t;
    eHr  = evt && (mMode == 1);
    eMin = evt && (mMode == 2);
    eClk = r && (mMode == 0);
    if (nMode != mMode || evt) lastRestart = t;
    off = ((t - lastRestart) / BLINK) % 2;
    eBh = (nMode == 1) && (off == 1);
    eBm = (nMode == 2) && (off == 1);
    mMode = nMode;
    eMode = nMode;
    prevM = m; prevU = u;
    lowM = lowM | !m; lowU = lowU | !u;
  endtask

  task automatic tick(input logic m, input logic u, input logic r);
    btn_mode = m; btn_up = u; run_en = r;
    @(posedge clk); #1;
    modelStep(m, u, r);
    chk("mode", mode, eMode);
    chk("hrup", hrup, eHr);
    chk("minup", minup, eMin);
    chk("blank_hr", blank_hr, eBh);
    chk("blank_min", blank_min, eBm);
    chk("clk_en", clk_en, eClk);
    chk("pulse_exclusive", hrup & minup, 0);
    chk("pulse_single", (hrup & lastHr) | (minup & lastMin), 0);
    if (hrup === 1'b1) hrCnt++;
    if (minup === 1'b1) minCnt++;
    lastHr = hrup; lastMin = minup;
  endtask

  task automatic doReset(input logic u);
    btn_up = u; btn_mode = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("rst_mode", mode, 0);
    chk("rst_hrup", hrup, 0);
    chk("rst_minup", minup, 0);
    chk("rst_blank_hr", blank_hr, 0);
    chk("rst_blank_min", blank_min, 0);
    chk("rst_clk_en", clk_en, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    modelReset();
  endtask

  initial begin
    logic [31:0] mask;
    int firstRun, toggles;
    logic prevBlank;
    logic rm, ru, rr;

    doReset(1'b0);
    repeat (3) tick(0, 0, 1);
    tick(0, 0, 0);
    tick(0, 0, 1);

    // Two mode presses then a one-cycle up press: one minute pulse only.
    hrCnt = 0; minCnt = 0;
    tick(1, 0, 1); tick(0, 0, 1);
    tick(1, 0, 1); tick(0, 0, 1);
    tick(0, 1, 1); tick(0, 0, 1); tick(0, 0, 1);
    chk("setmin_mode", mode, 2);
    chk("setmin_minup_count", minCnt, 1);
    chk("setmin_hrup_count", hrCnt, 0);

    // Back to RUN, into SET_HR, then hold up for 20 cycles.
    tick(1, 0, 1); tick(0, 0, 1);
    tick(1, 0, 1); tick(0, 0, 1);
    mask = '0;
    for (int i = 0; i < 21; i++) begin
      tick(0, (i < 20), 1);
      if (hrup === 1'b1) mask = mask | (32'd1 << (i + 1));
    end
    chk("hold_offsets", mask, (32'd1 << 1) | (32'd1 << 9) | (32'd1 << 13) | (32'd1 << 17));

    // Mode and up rising together in SET_HR: mode wins, no pulse.
    hrCnt = 0; minCnt = 0;
    tick(1, 1, 1);
    tick(0, 0, 1); tick(0, 0, 1); tick(0, 0, 1);
    chk("coincide_mode", mode, 2);
    chk("coincide_pulses", hrCnt + minCnt, 0);

    // Enter SET_HR and stay idle: blink and timeout.
    tick(1, 0, 1); tick(0, 0, 1);
    tick(1, 0, 1);
    firstRun = -1; toggles = 0; prevBlank = blank_hr;
    for (int i = 1; i <= 60; i++) begin
      tick(0, 0, 1);
      if (firstRun < 0 && mode == 2'd0) firstRun = i;
      if (mode == 2'd1 && blank_hr !== prevBlank) toggles++;
      prevBlank = blank_hr;
    end
    chk("timeout_cycle", firstRun, TIMEOUT);
    chk("blink_toggles", toggles, 9);
    chk("clk_en_after_timeout", clk_en, 1);

    // Reset in the middle of a SET_MIN repeat with up still held.
    tick(1, 0, 1); tick(0, 0, 1);
    tick(1, 0, 1); tick(0, 0, 1);
    for (int i = 0; i < 11; i++) tick(0, 1, 1);
    doReset(1'b1);
    minCnt = 0;
    repeat (5) tick(0, 1, 1);
    tick(1, 1, 1); tick(0, 1, 1);
    tick(1, 1, 1); tick(0, 1, 1);
    repeat (15) tick(0, 1, 1);
    chk("post_reset_mode", mode, 2);
    chk("post_reset_no_minup", minCnt, 0);
    tick(0, 0, 1); tick(0, 1, 1); tick(0, 0, 1); tick(0, 0, 1);
    chk("repress_minup", minCnt, 1);

    // Randomized traffic with quiet stretches long enough to time out.
    rm = 0; ru = 0; rr = 1;
    for (int i = 0; i < 800; i++) begin
      if ((i % 200) >= 130) begin
        rm = 0;
        ru = 0;
      end else begin
        rm = ($urandom_range(0, 19) == 0);
        if ($urandom_range(0, 9) == 0) ru = ~ru;
      end
      if ($urandom_range(0, 29) == 0) rr = ~rr;
      tick(rm, ru, rr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
